// File: rtl/io_out_ports.sv
// CPU OUT-port latches for the two sound ports with rising-bit trigger pulses,
// plus a kickable watchdog that emits a fixed-length reset request on expiry.
module io_out_ports #(
    parameter int WDT_CYCLES = 2000000,
    parameter int WDT_PULSE  = 16,
    parameter int WDT_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [7:0]  io_wdata,
    input  logic        write_io,
    output logic [7:0]  snd_port3,
    output logic [7:0]  snd_port5,
    output logic [7:0]  snd_trig3,
    output logic [7:0]  snd_trig5,
    output logic        amp_enable,
    output logic [21:0] wdt_count,
    output logic        wdt_reset
);

    localparam int PW = $clog2(WDT_PULSE + 1);
    localparam logic [21:0]   TERM_COUNT = 22'(WDT_CYCLES - 1);
    localparam logic [PW-1:0] LAST_PULSE = PW'(WDT_PULSE - 1);

    typedef enum logic {RUN, FIRE} wdt_state_t;

    logic          write_q;
    logic          accept;
    logic          kick;
    wdt_state_t    state;
    logic [PW-1:0] pulse_cnt;

    // Only the first cycle of a (possibly long) OUT strobe is acted on.
    assign accept     = write_io & ~write_q;
    assign kick       = accept & (io_addr == 8'h06);
    assign amp_enable = snd_port3[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q   <= 1'b0;
            snd_port3 <= 8'h00;
            snd_port5 <= 8'h00;
            snd_trig3 <= 8'h00;
            snd_trig5 <= 8'h00;
        end else begin
            write_q   <= write_io;
            snd_trig3 <= 8'h00;
            snd_trig5 <= 8'h00;
            if (accept && io_addr == 8'h03) begin
                snd_port3 <= io_wdata;
                snd_trig3 <= io_wdata & ~snd_port3;
            end
            if (accept && io_addr == 8'h05) begin
                snd_port5 <= io_wdata;
                snd_trig5 <= io_wdata & ~snd_port5;
            end
        end
    end

    // The count never reaches WDT_CYCLES: terminal count moves to FIRE with
    // the count parked at 0 until the pulse has finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wdt_count <= 22'd0;
            wdt_reset <= 1'b0;
            pulse_cnt <= '0;
        end else if (WDT_ENABLE == 0) begin
            state     <= RUN;
            wdt_count <= 22'd0;
            wdt_reset <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (kick) begin
                        wdt_count <= 22'd0;
                    end else if (wdt_count == TERM_COUNT) begin
                        state     <= FIRE;
                        wdt_count <= 22'd0;
                        wdt_reset <= 1'b1;
                        pulse_cnt <= '0;
                    end else begin
                        wdt_count <= wdt_count + 22'd1;
                    end
                end
                FIRE: begin
                    wdt_count <= 22'd0;
                    if (pulse_cnt == LAST_PULSE) begin
                        state     <= RUN;
                        wdt_reset <= 1'b0;
                        pulse_cnt <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= RUN;
                    wdt_count <= 22'd0;
                    wdt_reset <= 1'b0;
                    pulse_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_out_ports.sv
// Directed bench for io_out_ports: expectations are queued against a cycle
// number and a free-running monitor compares them at mid-cycle.
module tb_io_out_ports;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        write_io;
    logic [7:0]  snd_port3;
    logic [7:0]  snd_port5;
    logic [7:0]  snd_trig3;
    logic [7:0]  snd_trig5;
    logic        amp_enable;
    logic [21:0] wdt_count;
    logic        wdt_reset;

    io_out_ports #(.WDT_CYCLES(100), .WDT_PULSE(4), .WDT_ENABLE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .write_io   (write_io),
        .snd_port3  (snd_port3),
        .snd_port5  (snd_port5),
        .snd_trig3  (snd_trig3),
        .snd_trig5  (snd_trig5),
        .amp_enable (amp_enable),
        .wdt_count  (wdt_count),
        .wdt_reset  (wdt_reset)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int P3 = 0, P5 = 1, T3 = 2, T5 = 3, AMP = 4, CNT = 5, WRST = 6;

    typedef struct {
        int          cyc;
        int          sel;
        logic [21:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   rel;
    int   rel2;
    int   s;

    function automatic string sel_name(int sel);
        case (sel)
            P3:      return "snd_port3";
            P5:      return "snd_port5";
            T3:      return "snd_trig3";
            T5:      return "snd_trig5";
            AMP:     return "amp_enable";
            CNT:     return "wdt_count";
            default: return "wdt_reset";
        endcase
    endfunction

    function automatic logic [21:0] actual(int sel);
        case (sel)
            P3:      return {14'd0, snd_port3};
            P5:      return {14'd0, snd_port5};
            T3:      return {14'd0, snd_trig3};
            T5:      return {14'd0, snd_trig5};
            AMP:     return {21'd0, amp_enable};
            CNT:     return wdt_count;
            default: return {21'd0, wdt_reset};
        endcase
    endfunction

    function void expect_abs(int c, int sel, logic [21:0] val);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endfunction

    // scoreboard monitor
    always begin
        @(negedge clk);
        #2;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                tests_run++;
                if (exp_q[i].cyc < cyc) begin
                    tests_failed++;
                    $display("FAIL %s missed check at cycle %0d", sel_name(exp_q[i].sel), exp_q[i].cyc);
                end else if (actual(exp_q[i].sel) !== exp_q[i].val) begin
                    tests_failed++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h",
                             sel_name(exp_q[i].sel), cyc, actual(exp_q[i].sel), exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
    end

    // driver tasks
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic out_write(logic [7:0] addr, logic [7:0] data);
        io_addr  = addr;
        io_wdata = data;
        write_io = 1'b1;
        tick(1);
        write_io = 1'b0;
        tick(1);
    endtask

    // Single-cycle write to port 3 or 5 with its expected latch and pulse.
    task automatic port_write(logic [7:0] addr, logic [7:0] data,
                              logic [7:0] exp_port, logic [7:0] exp_trig);
        s = cyc;
        expect_abs(s + 1, (addr == 8'h03) ? P3 : P5, {14'd0, exp_port});
        expect_abs(s + 1, (addr == 8'h03) ? T3 : T5, {14'd0, exp_trig});
        expect_abs(s + 2, (addr == 8'h03) ? T3 : T5, 22'd0);
        out_write(addr, data);
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        write_io = 1'b0;
        io_addr  = 8'h00;
        io_wdata = 8'h00;
        tick(3);
        for (int k = 0; k <= WRST; k++) expect_abs(cyc, k, 22'd0);
        tick(1);
        rst = 1'b0;
        rel = cyc;

        // first expiry, no kicks anywhere before it
        expect_abs(rel + 1,   CNT,  22'd1);
        expect_abs(rel + 99,  CNT,  22'd99);
        expect_abs(rel + 99,  WRST, 22'd0);
        expect_abs(rel + 100, WRST, 22'd1);
        expect_abs(rel + 100, CNT,  22'd0);
        expect_abs(rel + 103, WRST, 22'd1);
        expect_abs(rel + 103, CNT,  22'd0);
        expect_abs(rel + 104, WRST, 22'd0);
        expect_abs(rel + 104, CNT,  22'd0);
        expect_abs(rel + 105, CNT,  22'd1);
        tick(1);

        // port 3 rising-bit triggers
        port_write(8'h03, 8'h01, 8'h01, 8'h01);
        port_write(8'h03, 8'h03, 8'h03, 8'h02);
        port_write(8'h03, 8'h03, 8'h03, 8'h00);
        port_write(8'h03, 8'h01, 8'h01, 8'h00);
        expect_abs(cyc + 1, AMP, 22'd1);
        port_write(8'h03, 8'h21, 8'h21, 8'h20);
        port_write(8'h03, 8'hA5, 8'hA5, 8'h84);

        // port 5 with the strobe held and data changing underneath
        s = cyc;
        expect_abs(s + 1, P5, 22'h10);
        expect_abs(s + 1, T5, 22'h10);
        expect_abs(s + 2, P5, 22'h10);
        expect_abs(s + 2, T5, 22'h00);
        expect_abs(s + 4, P5, 22'h10);
        expect_abs(s + 4, T5, 22'h00);
        io_addr  = 8'h05;
        io_wdata = 8'h10;
        write_io = 1'b1;
        tick(1);
        io_wdata = 8'h20;
        tick(3);
        write_io = 1'b0;
        tick(1);
        port_write(8'h05, 8'h30, 8'h30, 8'h20);

        // unrelated port changes nothing
        s = cyc;
        expect_abs(s + 1, P3, 22'hA5);
        expect_abs(s + 1, P5, 22'h30);
        expect_abs(s + 1, T3, 22'h00);
        expect_abs(s + 1, T5, 22'h00);
        expect_abs(s + 1, AMP, 22'd1);
        out_write(8'h04, 8'hFF);

        // kick exactly at terminal count wins
        wait_until(rel + 203);
        expect_abs(rel + 203, CNT,  22'd99);
        expect_abs(rel + 204, CNT,  22'd0);
        expect_abs(rel + 204, WRST, 22'd0);
        expect_abs(rel + 205, CNT,  22'd1);
        expect_abs(rel + 205, WRST, 22'd0);
        out_write(8'h06, 8'hFF);

        // kick during the pulse is ignored
        wait_until(rel + 305);
        expect_abs(rel + 306, WRST, 22'd1);
        expect_abs(rel + 307, WRST, 22'd1);
        expect_abs(rel + 308, WRST, 22'd0);
        expect_abs(rel + 308, CNT,  22'd0);
        expect_abs(rel + 309, CNT,  22'd1);
        out_write(8'h06, 8'h00);

        // reset mid-pulse, together with a write that must be dropped
        wait_until(rel + 408);
        expect_abs(cyc, WRST, 22'd1);
        tick(1);
        io_addr  = 8'h05;
        io_wdata = 8'hAA;
        write_io = 1'b1;
        rst      = 1'b1;
        expect_abs(cyc, WRST, 22'd0);
        expect_abs(cyc, CNT,  22'd0);
        expect_abs(cyc, P3,   22'd0);
        expect_abs(cyc, P5,   22'd0);
        expect_abs(cyc + 1, P5, 22'd0);
        tick(1);

        // strobe already high at reset release is taken on the first edge
        io_addr  = 8'h03;
        io_wdata = 8'h55;
        rst      = 1'b0;
        rel2     = cyc;
        expect_abs(rel2 + 1, P3,  22'h55);
        expect_abs(rel2 + 1, T3,  22'h55);
        expect_abs(rel2 + 1, P5,  22'h00);
        expect_abs(rel2 + 1, CNT, 22'd1);
        expect_abs(rel2 + 2, T3,  22'h00);
        tick(1);
        write_io = 1'b0;
        tick(1);

        s = cyc;
        expect_abs(s + 1, P3,   22'h55);
        expect_abs(s + 1, P5,   22'h00);
        expect_abs(s + 1, T3,   22'h00);
        expect_abs(s + 1, T5,   22'h00);
        expect_abs(s + 1, WRST, 22'd0);
        expect_abs(s + 1, CNT,  22'(s + 1 - rel2));
        out_write(8'h04, 8'hFF);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick(1);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/io_out_ports.md
IO_OUT_PORTS -- requirements
Module: io_out_ports

Interface
REQ-001 SHALL have parameter WDT_CYCLES, default 2000000; watchdog timeout in clk cycles (1 s at 2 MHz).
REQ-002 SHALL have parameter WDT_PULSE, default 16; wdt_reset pulse length in clk cycles.
REQ-003 SHALL have parameter WDT_ENABLE, default 1; 0 ties wdt_reset low and freezes the counter at 0.
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-005 Port list:
- clk  in  1  system clock (CPU clock domain)
- rst  in  1  asynchronous, active-high reset
- io_addr  in  8  CPU I/O port address (low address byte)
- io_wdata  in  8  CPU data bus value during OUT
- write_io  in  1  OUT write strobe (write_n low and status OUT); may stay high for several cycles
- snd_port3  out  8  latched port 3 value
- snd_port5  out  8  latched port 5 value
- snd_trig3  out  8  one-cycle rising-bit pulses for port 3
- snd_trig5  out  8  one-cycle rising-bit pulses for port 5
- amp_enable  out  1  equals snd_port3[5]
- wdt_count  out  22  current watchdog count (debug)
- wdt_reset  out  1  watchdog-expired reset request to the system

Function
REQ-006 SHALL register write_io every cycle (write_q) and accept a write only in a cycle where write_io=1 and write_q=0; later cycles of the same strobe SHALL be ignored.
REQ-007 Accepted write with io_addr=8'h03 SHALL load io_wdata into snd_port3; the new value SHALL be visible in the next cycle.
REQ-008 Accepted write with io_addr=8'h05 SHALL load io_wdata into snd_port5; the new value SHALL be visible in the next cycle.
REQ-009 Accepted write with io_addr=8'h06 SHALL be a watchdog kick; data SHALL be ignored.
REQ-010 Writes to any other address SHALL change no state in this block.
REQ-011 In the cycle after a port 3 or port 5 load, snd_trigN SHALL equal new & ~old for that port, bitwise; in all other cycles it SHALL be 0.
REQ-012 Each trigger pulse SHALL last exactly one cycle; rewriting the same value SHALL produce no pulse, and clearing a bit (1->0) SHALL produce no pulse.
REQ-013 Trigger pulses SHALL be generated whatever the value of amp_enable; the downstream sound block applies gating.
REQ-014 Watchdog states: RUN and FIRE.
REQ-015 In RUN, wdt_count SHALL increment by 1 per cycle.
REQ-016 In RUN, a kick SHALL clear wdt_count to 0 in the next cycle.
REQ-017 In RUN, when wdt_count=WDT_CYCLES-1 and there is no kick that cycle, the block SHALL enter FIRE in the next cycle with wdt_count=0.
REQ-018 If a kick and the terminal count occur in the same cycle, the kick SHALL win: the block stays in RUN and the count goes to 0.
REQ-019 In FIRE, wdt_reset SHALL be 1 for exactly WDT_PULSE cycles and wdt_count SHALL hold at 0.
REQ-020 Kicks during FIRE SHALL be ignored and SHALL NOT shorten the pulse.
REQ-021 After FIRE the block SHALL return to RUN with wdt_count counting from 0.
REQ-022 wdt_count SHALL never reach or exceed WDT_CYCLES, so there is no wrap-around; the pulse counter width SHALL be $clog2(WDT_PULSE+1).
REQ-023 All outputs SHALL be registered, except amp_enable, which is a wire from the snd_port3 register.

Reset
REQ-024 While rst=1, the block SHALL hold snd_port3=0, snd_port5=0, snd_trig3=0, snd_trig5=0, wdt_count=0, wdt_reset=0, write_q=0, state=RUN, and the pulse counter at 0.
REQ-025 rst asserted mid-FIRE SHALL drop wdt_reset immediately, without waiting for a clock edge.
REQ-026 A write_io already high when rst deasserts SHALL be accepted on the first clock edge after reset, because write_q=0.
REQ-027 rst asserted in the same cycle as an accepted write SHALL discard that write.

Verification
REQ-028 Port 3 trigger: write 8'h01 to port 3, then 8'h03 -> snd_port3=8'h03 and snd_trig3=8'h02 for one cycle, then 8'h00.
REQ-029 Held strobe: write_io high for 4 cycles with io_addr=8'h05 and io_wdata changing 8'h10 then 8'h20 -> snd_port5=8'h10 and snd_trig5=8'h10 pulses once.
REQ-030 Watchdog expiry: WDT_CYCLES=100, WDT_PULSE=4, no kicks -> wdt_reset high during cycles 100-103 after reset release, then the count restarts from 0.
REQ-031 Kick at terminal count: WDT_CYCLES=100, port 6 write accepted exactly when wdt_count=99 -> no wdt_reset and wdt_count=0 in the next cycle.
REQ-032 Reset during FIRE and write to another port: rst pulse during FIRE -> wdt_reset=0 immediately; write 8'hFF to port 4 -> all outputs unchanged.
